// File: rtl/timer_pkg.sv
// Shared digit width and per-digit wrap limits for the M:SS countdown timer.
package timer_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] MIN_MAX      = 4'd9;
endpackage

// File: rtl/bcd_down_digit.sv
// One down-counting BCD digit: load, decrement with wrap-to-MAX and borrow-out.
// Optional TIMER_MMSS_CLAMP_EN clamps out-of-range load values to MAX.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] data,
    input  logic               dec,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow,
    output logic               is_zero
);
    logic [DIGIT_W-1:0] r_q;
    logic [DIGIT_W-1:0] w_load_val;

`ifdef TIMER_MMSS_CLAMP_EN
    assign w_load_val = (data > MAX) ? MAX : data;
`else
    assign w_load_val = data;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= w_load_val;
        end else if (dec) begin
            r_q <= (r_q == '0) ? MAX : r_q - 1'b1;
        end
    end

    assign q       = r_q;
    assign is_zero = (r_q == '0);
    assign borrow  = dec && is_zero;
endmodule

// File: rtl/timer_mmss.sv
// M:SS BCD countdown timer with internal 1 s prescaler, zero flag and done pulse.
// Optional TIMER_MMSS_CLAMP_EN clamps out-of-range load digits (see bcd_down_digit).
module timer_mmss
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               loadn,
    input  logic               en,
    input  logic [DIGIT_W-1:0] data_sec_ones,
    input  logic [DIGIT_W-1:0] data_sec_tens,
    input  logic [DIGIT_W-1:0] data_min,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_digit,
    output logic               zero,
    output logic               done
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] r_presc;
    logic          r_done;
    logic          w_load;
    logic          w_count;
    logic          w_tick;
    logic          w_last_sec;
    logic          w_ones_borrow, w_tens_borrow, w_min_borrow;
    logic          w_ones_zero, w_tens_zero, w_min_zero;

    assign w_load  = !loadn;
    assign w_count = en && !zero && !w_load;
    assign w_tick  = w_count && (r_presc == PRESC_LAST);

    // Prescaler sits at 0 while the count is at 0:00 so the next load starts a full second.
    always_ff @(posedge clock) begin
        if (clear || w_load || zero) begin
            r_presc <= '0;
        end else if (w_count) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    bcd_down_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clock   (clock),
        .clear   (clear),
        .load    (w_load),
        .data    (data_sec_ones),
        .dec     (w_tick),
        .q       (sec_ones),
        .borrow  (w_ones_borrow),
        .is_zero (w_ones_zero)
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clock   (clock),
        .clear   (clear),
        .load    (w_load),
        .data    (data_sec_tens),
        .dec     (w_ones_borrow),
        .q       (sec_tens),
        .borrow  (w_tens_borrow),
        .is_zero (w_tens_zero)
    );

    // Minutes borrow-out is never consumed: counting halts at 0:00 before it could wrap.
    bcd_down_digit #(.MAX(MIN_MAX)) u_min (
        .clock   (clock),
        .clear   (clear),
        .load    (w_load),
        .data    (data_min),
        .dec     (w_tens_borrow),
        .q       (min_digit),
        .borrow  (w_min_borrow),
        .is_zero (w_min_zero)
    );

    assign zero       = w_ones_zero && w_tens_zero && w_min_zero;
    assign w_last_sec = (sec_ones == 4'd1) && w_tens_zero && w_min_zero;

    always_ff @(posedge clock) begin
        if (clear || w_load) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_tick && w_last_sec;
        end
    end

    assign done = r_done;

    logic w_unused;
    assign w_unused = w_min_borrow;
endmodule

// File: tb/tb_timer_mmss.sv
// Randomized and directed checks of timer_mmss against a digit-level countdown model.
module tb_timer_mmss;
    localparam int TPS = 4;

    logic       clock = 1'b0;
    logic       clear, loadn, en;
    logic [3:0] data_sec_ones, data_sec_tens, data_min;
    logic [3:0] sec_ones, sec_tens, min_digit;
    logic       zero, done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: M, T, O digits as integers plus enabled-cycle phase within the second.
    int m_min, m_tens, m_ones, m_ph;
    bit m_done;

    timer_mmss #(.TICKS_PER_SEC(TPS)) dut (
        .clock         (clock),
        .clear         (clear),
        .loadn         (loadn),
        .en            (en),
        .data_sec_ones (data_sec_ones),
        .data_sec_tens (data_sec_tens),
        .data_min      (data_min),
        .sec_ones      (sec_ones),
        .sec_tens      (sec_tens),
        .min_digit     (min_digit),
        .zero          (zero),
        .done          (done)
    );

    always #5 clock = ~clock;

    function automatic bit m_zero();
        return (m_min == 0) && (m_tens == 0) && (m_ones == 0);
    endfunction

    function automatic int clampv(input int v, input int mx);
`ifdef TIMER_MMSS_CLAMP_EN
        return (v > mx) ? mx : v;
`else
        return v;
`endif
    endfunction

    task automatic step(input logic c, input logic l, input logic e,
                        input logic [3:0] dm, input logic [3:0] dt, input logic [3:0] d1);
        bit last;
        clear = c; loadn = l; en = e;
        data_min = dm; data_sec_tens = dt; data_sec_ones = d1;
        @(posedge clock);
        if (c) begin
            m_min = 0; m_tens = 0; m_ones = 0; m_ph = 0; m_done = 0;
        end else if (!l) begin
            m_min = clampv(int'(dm), 9); m_tens = clampv(int'(dt), 5);
            m_ones = clampv(int'(d1), 9); m_ph = 0; m_done = 0;
        end else if (e && !m_zero()) begin
            m_ph++;
            m_done = 0;
            if (m_ph == TPS) begin
                m_ph = 0;
                last = (m_min == 0) && (m_tens == 0) && (m_ones == 1);
                if (m_ones > 0) m_ones--;
                else begin
                    m_ones = 9;
                    if (m_tens > 0) m_tens--;
                    else begin m_tens = 5; m_min--; end
                end
                m_done = last;
            end
        end else begin
            m_done = 0;
        end
        #1;
    endtask

    task automatic idle(input logic e);
        step(1'b0, 1'b1, e, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones, zero, done} !== {4'd0, 4'd0, 4'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got %0d:%0d%0d z=%0b d=%0b, want 0:00 z=1 d=0",
                     min_digit, sec_tens, sec_ones, zero, done);
        end
    endtask

    task automatic test_countdown_012();
        logic [11:0] want [4];
        want[0] = 12'h011; want[1] = 12'h010; want[2] = 12'h009; want[3] = 12'h008;
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
        for (int i = 1; i <= 16; i++) begin
            idle(1'b1);
            if (i % 4 == 0) begin
                n_cmp++;
                if ({min_digit, sec_tens, sec_ones} !== want[i/4-1]) begin
                    n_fail++;
                    $display("FAIL count012 cyc%0d: got %h, want %h", i,
                             {min_digit, sec_tens, sec_ones}, want[i/4-1]);
                end
            end
        end
    endtask

    task automatic test_double_borrow();
        int pulses = 0;
        int pulse_cyc = -1;
        int zero_cyc = -1;
        step(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones} !== 12'h059) begin
            n_fail++;
            $display("FAIL borrow100: got %h, want 059", {min_digit, sec_tens, sec_ones});
        end
        for (int i = 0; i < 260; i++) begin
            idle(1'b1);
            if (done) begin pulses++; pulse_cyc = i; end
            if (zero && zero_cyc < 0) zero_cyc = i;
        end
        n_cmp++;
        if (pulses !== 1 || zero_cyc < 0 || pulse_cyc !== zero_cyc) begin
            n_fail++;
            $display("FAIL done_pulse: got pulses=%0d at %0d zero at %0d, want 1 pulse at zero edge",
                     pulses, pulse_cyc, zero_cyc);
        end
        n_cmp++;
        if (zero_cyc !== 59 * TPS - 1) begin
            n_fail++;
            $display("FAIL zero_time: got cycle %0d, want %0d", zero_cyc, 59 * TPS - 1);
        end
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones, zero, done} !== {12'h000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_zero: got %h z=%0b d=%0b, want 000 z=1 d=0",
                     {min_digit, sec_tens, sec_ones}, zero, done);
        end
    endtask

    task automatic test_pause();
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5);
        idle(1'b1); idle(1'b1);
        for (int i = 0; i < 10; i++) idle(1'b0);
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones} !== 12'h005) begin
            n_fail++;
            $display("FAIL pause_hold: got %h, want 005", {min_digit, sec_tens, sec_ones});
        end
        idle(1'b1);
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones} !== 12'h005) begin
            n_fail++;
            $display("FAIL pause_early: got %h, want 005", {min_digit, sec_tens, sec_ones});
        end
        idle(1'b1);
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones} !== 12'h004) begin
            n_fail++;
            $display("FAIL pause_resume: got %h, want 004", {min_digit, sec_tens, sec_ones});
        end
    endtask

    task automatic test_clear_with_load();
        step(1'b0, 1'b0, 1'b0, 4'd3, 4'd2, 4'd7);
        for (int i = 0; i < 3; i++) idle(1'b1);
        step(1'b1, 1'b0, 1'b1, 4'd9, 4'd5, 4'd9);
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones, zero, done} !== {12'h000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_load: got %h z=%0b d=%0b, want 000 z=1 d=0",
                     {min_digit, sec_tens, sec_ones}, zero, done);
        end
        idle(1'b1);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done: got %0b, want 0", done);
        end
    endtask

    task automatic test_load_zero();
        int pulses = 0;
        step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        n_cmp++;
        if (zero !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_zero: got z=%0b d=%0b, want z=1 d=0", zero, done);
        end
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL load_zero_done: got %0d pulses, want 0", pulses);
        end
    endtask

    task automatic test_load_on_tick();
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0);
        for (int i = 0; i < TPS - 1; i++) idle(1'b1);
        step(1'b0, 1'b0, 1'b1, 4'd0, 4'd4, 4'd5);
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones} !== 12'h045) begin
            n_fail++;
            $display("FAIL load_tick: got %h, want 045", {min_digit, sec_tens, sec_ones});
        end
        for (int i = 0; i < TPS; i++) idle(1'b1);
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones} !== 12'h044) begin
            n_fail++;
            $display("FAIL load_tick_next: got %h, want 044", {min_digit, sec_tens, sec_ones});
        end
    endtask

    task automatic test_out_of_range();
        logic [11:0] w0, w1;
`ifdef TIMER_MMSS_CLAMP_EN
        w0 = 12'h959; w1 = 12'h958;
`else
        w0 = 12'hC7F; w1 = 12'hC7E;
`endif
        step(1'b0, 1'b0, 1'b0, 4'd12, 4'd7, 4'd15);
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones} !== w0) begin
            n_fail++;
            $display("FAIL oor_load: got %h, want %h", {min_digit, sec_tens, sec_ones}, w0);
        end
        for (int i = 0; i < TPS; i++) idle(1'b1);
        n_cmp++;
        if ({min_digit, sec_tens, sec_ones} !== w1) begin
            n_fail++;
            $display("FAIL oor_tick: got %h, want %h", {min_digit, sec_tens, sec_ones}, w1);
        end
    endtask

    task automatic test_random();
        logic c, l, e;
        logic [3:0] dm, dt, d1;
        for (int i = 0; i < 1500; i++) begin
            c  = ($urandom_range(0, 199) == 0);
            l  = ($urandom_range(0, 59) != 0);
            e  = ($urandom_range(0, 3) != 0);
            dm = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            dt = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
            d1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            step(c, l, e, dm, dt, d1);
            n_cmp++;
            if ({min_digit, sec_tens, sec_ones, zero, done} !==
                {4'(m_min), 4'(m_tens), 4'(m_ones), m_zero(), m_done}) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h z=%0b d=%0b, want %h z=%0b d=%0b", i,
                         {min_digit, sec_tens, sec_ones}, zero, done,
                         {4'(m_min), 4'(m_tens), 4'(m_ones)}, m_zero(), m_done);
            end
        end
    endtask

    initial begin
        clear = 1'b1; loadn = 1'b1; en = 1'b0;
        data_min = '0; data_sec_tens = '0; data_sec_ones = '0;
        m_min = 0; m_tens = 0; m_ones = 0; m_ph = 0; m_done = 0;
        @(negedge clock);
        test_reset();
        test_countdown_012();
        test_double_borrow();
        test_pause();
        test_clear_with_load();
        test_load_zero();
        test_load_on_tick();
        test_out_of_range();
        test_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
